// File: rtl/mult_driver.sv
// Initiator-side controller for the shift-add multiplier: takes an operand pair,
// starts the multiplier, collects the product (or times out) and offers the result downstream.
module mult_driver #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               mul_valid_data,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_product,
    output logic               mul_ack,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_product,
    output logic               res_err,
    output logic [15:0]        done_count
);

    localparam int WD_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_ACK   = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t               state_reg, state_next;
    logic [WIDTH-1:0]     mul_a_reg, mul_b_reg;
    logic [2*WIDTH-1:0]   res_product_reg;
    logic                 res_err_reg;
    logic [WD_W-1:0]      wd_count_reg;
    logic [15:0]          done_count_reg;

    logic                 idle_flag;
    logic                 accept;
    logic                 capture_done;
    logic                 capture_timeout;
    logic                 deliver;
    logic                 wd_clear;
    logic                 wd_inc;
    logic                 wd_expired;

    assign wd_expired = (wd_count_reg == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        idle_flag       = 1'b0;
        mul_valid_data  = 1'b0;
        mul_ack         = 1'b0;
        res_valid       = 1'b0;
        accept          = 1'b0;
        capture_done    = 1'b0;
        capture_timeout = 1'b0;
        deliver         = 1'b0;
        wd_clear        = 1'b0;
        wd_inc          = 1'b0;
        case (state_reg)
            S_IDLE: begin
                idle_flag = 1'b1;
                if (op_valid) begin
                    accept     = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mul_valid_data = 1'b1;
                wd_clear       = 1'b1;
                state_next     = S_WAIT;
            end
            S_WAIT: begin
                wd_inc = 1'b1;
                // A product arriving on the last allowed cycle still counts as success.
                if (mul_done) begin
                    capture_done = 1'b1;
                    state_next   = S_ACK;
                end else if (wd_expired) begin
                    capture_timeout = 1'b1;
                    state_next      = S_ACK;
                end
            end
            S_ACK: begin
                mul_ack    = 1'b1;
                state_next = S_OUT;
            end
            S_OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    deliver    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a_reg       <= '0;
            mul_b_reg       <= '0;
            res_product_reg <= '0;
            res_err_reg     <= 1'b0;
            wd_count_reg    <= '0;
            done_count_reg  <= '0;
        end else begin
            if (accept) begin
                mul_a_reg <= op_a;
                mul_b_reg <= op_b;
            end
            if (wd_clear) begin
                wd_count_reg <= '0;
            end else if (wd_inc) begin
                wd_count_reg <= wd_count_reg + WD_W'(1);
            end
            if (capture_done) begin
                res_product_reg <= mul_product;
                res_err_reg     <= 1'b0;
            end else if (capture_timeout) begin
                res_product_reg <= '0;
                res_err_reg     <= 1'b1;
            end
            if (deliver) begin
                done_count_reg <= done_count_reg + 16'd1;
            end
        end
    end

    // Gated by reset so upstream never sees ready while the block is held in reset.
    assign op_ready    = idle_flag & rst_n;
    assign mul_a       = mul_a_reg;
    assign mul_b       = mul_b_reg;
    assign res_product = res_product_reg;
    assign res_err     = res_err_reg;
    assign done_count  = done_count_reg;

endmodule
